// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: access-size encodings,
// controller states and word-geometry helpers.
package dmem_pkg;

    // req_size encodings: log2 of the access width in bytes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // Bytes per stored word for a given data width
    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction

    // Number of low address bits that select a byte lane
    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Access width in bytes for a req_size code
    function automatic int size_bytes(input logic [1:0] sz);
        int n;
        unique case (sz)
            SZ_B: n = 1;
            SZ_H: n = 2;
            SZ_W: n = 4;
            SZ_D: n = 8;
            default: n = 1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_banked_ctrl_if.sv
// Request/response bus of the data memory.
// master drives req_* and samples rsp_*; slave is the memory side.
interface dmem_banked_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for the data memory (combinational).
// Ports: size/lane/sign_ext describe the access; wdata -> be/wdata_sh
// (store path); rword -> rdata (load path, right-justified, extended).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]                          size,
    input  logic [lane_bits(DATA_WIDTH)-1:0]    lane,
    input  logic                                sign_ext,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [DATA_WIDTH-1:0]               rword,
    output logic [bytes_per_word(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]               wdata_sh,
    output logic [DATA_WIDTH-1:0]               rdata
);
    localparam int BPW = bytes_per_word(DATA_WIDTH);

    int                    nb;
    int                    sh;
    logic [BPW-1:0]        be_raw;
    logic [DATA_WIDTH-1:0] vmask;
    logic [DATA_WIDTH-1:0] raw;
    logic                  sbit;

    always_comb begin
        // Oversized/straddling accesses are flagged as errors upstream;
        // clamp here so the steering stays in range.
        nb = size_bytes(size);
        if (nb > BPW) nb = BPW;
        // Lowest address is the MSB lane, so the value's top byte lands
        // at lane and its bottom byte BPW-lane-nb lanes above bit 0.
        if (nb + int'(lane) > BPW) sh = 0;
        else sh = BPW - int'(lane) - nb;

        be_raw = '0;
        for (int b = 0; b < BPW; b++) be_raw[b] = (b < nb);
        vmask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) vmask[i] = (i < 8 * nb);

        be       = be_raw << sh;
        wdata_sh = (wdata & vmask) << (8 * sh);

        raw   = (rword >> (8 * sh)) & vmask;
        sbit  = raw[8 * nb - 1];
        rdata = (sign_ext && sbit) ? (raw | ~vmask) : raw;
    end
endmodule

// File: rtl/dmem_banked_ctrl.sv
// Byte-addressed big-endian data memory with self-clear after reset and
// 1-cycle registered response. Ports: clk, reset (async, active-high),
// bus (dmem_banked_ctrl_if.slave), init_done. Optional DMEM_LOW_PROTECT_EN
// makes accesses below PROTECT_LIMIT complete silently.
module dmem_banked_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int ADDR_WIDTH    = 32,
    parameter int PROTECT_LIMIT = 32
) (
    input  logic              clk,
    input  logic              reset,
    dmem_banked_ctrl_if.slave bus,
    output logic              init_done
);
    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int LW  = lane_bits(DATA_WIDTH);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_LOW_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [IW-1:0]         clr_idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic [2:0]            amask;
    logic                  misalign, oversize, range_err, err, prot;
    logic [ADDR_WIDTH-1:0] widx;
    logic [IW-1:0]         idx;
    logic [BPW-1:0]        be;
    logic [DATA_WIDTH-1:0] wdata_sh, ld_data;
    logic                  do_store;

    // Request decode
    always_comb begin
        amask     = 3'(size_bytes(bus.req_size) - 1);
        oversize  = int'(bus.req_size) > LW;
        misalign  = |(bus.req_addr[2:0] & amask);
        widx      = bus.req_addr >> LW;
        range_err = widx >= ADDR_WIDTH'(DEPTH);
        idx       = widx[IW-1:0];
        err       = oversize | misalign | range_err;
        prot      = PROT_EN & (bus.req_addr < ADDR_WIDTH'(PROTECT_LIMIT));
        accept    = bus.req_valid & bus.req_ready;
        do_store  = accept & bus.req_write & ~err & ~prot;
    end

    dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size     (bus.req_size),
        .lane     (bus.req_addr[LW-1:0]),
        .sign_ext (bus.req_signed),
        .wdata    (bus.req_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) clr_idx <= clr_idx + 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && clr_idx == IW'(DEPTH - 1)) state_d = ST_RUN;
    end

    // FSM outputs
    always_comb begin
        bus.req_ready = (state_q == ST_RUN);
        init_done     = (state_q == ST_RUN);
    end

    // Array: clear sweep in INIT, byte-masked store in RUN
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < BPW; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    // Response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_error <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= accept;
            bus.rsp_error <= accept & err;
            bus.rsp_rdata <= (accept && !bus.req_write && !err && !prot)
                             ? ld_data : '0;
        end
    end
endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Directed self-checking bench for dmem_banked_ctrl (32-bit, 256 words).
// Honours DMEM_LOW_PROTECT_EN for the low-window scenario.
module tb_dmem_banked_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    int   errors = 0;
    int   checks = 0;

    dmem_banked_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_banked_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .PROTECT_LIMIT(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Counts rising edges after reset release until init_done; also notes
    // any early ready or stray response. Bounded by DEPTH+8 edges.
    task automatic wait_init(output int rise, output logic early, output logic stray);
        rise  = -1;
        early = 1'b0;
        stray = 1'b0;
        for (int c = 1; c <= DEPTH + 8; c++) begin
            step();
            if (bus.rsp_valid) stray = 1'b1;
            if (bus.req_ready && !init_done) early = 1'b1;
            if (c < DEPTH && bus.req_ready) early = 1'b1;
            if (init_done) begin
                rise = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int rise;
        logic early, stray;
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        reset = 1'b1;
        #12;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", bus.rsp_error); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        @(negedge clk);
        reset = 1'b0;
        wait_init(rise, early, stray);
        checks++; if (rise != DEPTH) begin errors++; $display("FAIL init_latency: got %0d want %0d", rise, DEPTH); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL init_ready_early: got %b want 0", early); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL run_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_word_byte;
        drive(1, 1, 2'd2, 0, 32'h40, 32'hDEADBEEF);
        step();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL st_w_ack: got v=%b e=%b d=%h want v=1 e=0 d=0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
        drive(1, 0, 2'd2, 0, 32'h40, 32'h0);
        step();
        checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_w: got %h want deadbeef", bus.rsp_rdata); end
        drive(1, 0, 2'd0, 1, 32'h41, 32'h0);
        step();
        checks++; if (bus.rsp_rdata !== 32'hFFFFFFAD) begin errors++; $display("FAIL ld_b_signed: got %h want ffffffad", bus.rsp_rdata); end
        drive(1, 0, 2'd0, 0, 32'h41, 32'h0);
        step();
        checks++; if (bus.rsp_rdata !== 32'h000000AD) begin errors++; $display("FAIL ld_b_unsigned: got %h want 000000ad", bus.rsp_rdata); end
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", bus.rsp_valid); end
    endtask

    task automatic test_half;
        drive(1, 1, 2'd1, 0, 32'h46, 32'hFFFF1234);
        step();
        drive(1, 0, 2'd2, 0, 32'h44, 32'h0);
        step();
        checks++; if (bus.rsp_rdata !== 32'h00001234 || bus.rsp_error !== 1'b0) begin
            errors++; $display("FAIL st_h_ld_w: got %h e=%b want 00001234 e=0", bus.rsp_rdata, bus.rsp_error); end
    endtask

    task automatic test_errors;
        drive(1, 0, 2'd1, 0, 32'h43, 32'h0);
        step();
        checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL misalign_h: got e=%b d=%h want e=1 d=0", bus.rsp_error, bus.rsp_rdata); end
        drive(1, 0, 2'd2, 0, 32'h42, 32'h0);
        step();
        checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL misalign_w: got e=%b d=%h want e=1 d=0", bus.rsp_error, bus.rsp_rdata); end
        drive(1, 0, 2'd3, 0, 32'h40, 32'h0);
        step();
        checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL oversize_d: got e=%b d=%h want e=1 d=0", bus.rsp_error, bus.rsp_rdata); end
        drive(1, 1, 2'd2, 0, DEPTH * 4, 32'hCAFEF00D);
        step();
        checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL range_st: got e=%b v=%b want e=1 v=1", bus.rsp_error, bus.rsp_valid); end
        drive(1, 0, 2'd2, 0, DEPTH * 4, 32'h0);
        step();
        checks++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL range_ld: got e=%b d=%h want e=1 d=0", bus.rsp_error, bus.rsp_rdata); end
        drive(1, 0, 2'd2, 0, 32'h0, 32'h0);
        step();
        checks++; if (bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL range_no_alias: got e=%b d=%h want e=0 d=0", bus.rsp_error, bus.rsp_rdata); end
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        step();
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    task automatic test_back_to_back;
        vec_t v [8];
        int rise;
        logic early, stray;
        v[0] = '{1, 2'd2, 0, 32'h80, 32'h11223344, 32'h0};
        v[1] = '{0, 2'd2, 0, 32'h80, 32'h0,        32'h11223344};
        v[2] = '{1, 2'd0, 0, 32'h81, 32'h000000A5, 32'h0};
        v[3] = '{0, 2'd0, 0, 32'h81, 32'h0,        32'h000000A5};
        v[4] = '{1, 2'd1, 0, 32'h82, 32'h00008001, 32'h0};
        v[5] = '{0, 2'd1, 1, 32'h82, 32'h0,        32'hFFFF8001};
        v[6] = '{1, 2'd0, 0, 32'h80, 32'h0000007F, 32'h0};
        v[7] = '{0, 2'd2, 0, 32'h80, 32'h0,        32'h7FA58001};
        for (int i = 0; i < 8; i++) begin
            drive(1, v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].d);
            step();
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_rdata !== v[i].exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.rsp_rdata, v[i].exp); end
        end
        // Load held across a mid-stream reset and the whole clear sweep
        drive(1, 0, 2'd2, 0, 32'h80, 32'h0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        reset = 1'b0;
        wait_init(rise, early, stray);
        checks++; if (rise != DEPTH) begin errors++; $display("FAIL reinit_latency: got %0d want %0d", rise, DEPTH); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL init_ignores_req: got %b want 0", stray); end
        step();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL cleared_data: got v=%b d=%h want v=1 d=0", bus.rsp_valid, bus.rsp_rdata); end
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_low_protect;
        logic [31:0] exp;
`ifdef DMEM_LOW_PROTECT_EN
        exp = 32'h0;
`else
        exp = 32'h000000FF;
`endif
        drive(1, 1, 2'd2, 0, 32'h10, 32'h000000FF);
        step();
        checks++; if (bus.rsp_error !== 1'b0 || bus.rsp_valid !== 1'b1) begin
            errors++; $display("FAIL low_st: got e=%b v=%b want e=0 v=1", bus.rsp_error, bus.rsp_valid); end
        drive(1, 0, 2'd2, 0, 32'h10, 32'h0);
        step();
        checks++; if (bus.rsp_rdata !== exp || bus.rsp_error !== 1'b0) begin
            errors++; $display("FAIL low_ld: got %h e=%b want %h e=0", bus.rsp_rdata, bus.rsp_error, exp); end
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0);
        step();
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_low_protect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
